// File: rtl/modexp_ctrl.sv
// modexp_ctrl - modular-exponentiation sequencer for the RSA core.
//
// Computes result = X^E mod M by left-to-right binary square-and-multiply
// in the Montgomery domain. Every product is delegated to one external
// Montgomery multiplier through a start/done handshake. Operands are
// registered and held stable while each multiplication is outstanding.
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   start               request, sampled only when idle
//   in_x, in_e, e_len   base, exponent, exponent length (clipped to N)
//   in_m, in_r, in_r2   odd modulus, R mod M, R^2 mod M (R = 2^N)
//   mm_start            one-cycle multiply request
//   mm_a, mm_b, mm_m    multiplier operands
//   mm_done, mm_result  multiply completion and product a*b*R^-1 mod M
//   busy                high from the cycle after start through the done cycle
//   done                one-cycle completion pulse
//   result              X^E mod M, held until overwritten by the next run
module modexp_ctrl #(
    parameter int N  = 1024,
    parameter int EW = 11
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [N-1:0]  in_x,
    input  logic [N-1:0]  in_e,
    input  logic [EW-1:0] e_len,
    input  logic [N-1:0]  in_m,
    input  logic [N-1:0]  in_r,
    input  logic [N-1:0]  in_r2,
    output logic          mm_start,
    output logic [N-1:0]  mm_a,
    output logic [N-1:0]  mm_b,
    output logic [N-1:0]  mm_m,
    input  logic          mm_done,
    input  logic [N-1:0]  mm_result,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result
);

    localparam int            IW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [EW-1:0] MAX_LEN = EW'(N);
    localparam logic [N-1:0]  ONE     = N'(1);

    typedef enum logic [2:0] {
        IDLE,
        TO_MONT_W,
        SQ_W,
        MUL_W,
        FROM_W
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  e_reg, e_nxt;
    logic          len_zero, len_zero_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [N-1:0]  acc, acc_nxt;
    logic [N-1:0]  xt, xt_nxt;
    logic          mm_start_nxt, busy_nxt, done_nxt;
    logic [N-1:0]  mm_a_nxt, mm_b_nxt, mm_m_nxt, result_nxt;
    logic [EW-1:0] len_clip;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            e_reg    <= '0;
            len_zero <= 1'b0;
            idx      <= '0;
            acc      <= '0;
            xt       <= '0;
            mm_start <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
            mm_m     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            state    <= state_nxt;
            e_reg    <= e_nxt;
            len_zero <= len_zero_nxt;
            idx      <= idx_nxt;
            acc      <= acc_nxt;
            xt       <= xt_nxt;
            mm_start <= mm_start_nxt;
            mm_a     <= mm_a_nxt;
            mm_b     <= mm_b_nxt;
            mm_m     <= mm_m_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            result   <= result_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        e_nxt        = e_reg;
        len_zero_nxt = len_zero;
        idx_nxt      = idx;
        acc_nxt      = acc;
        xt_nxt       = xt;
        mm_start_nxt = 1'b0;
        mm_a_nxt     = mm_a;
        mm_b_nxt     = mm_b;
        mm_m_nxt     = mm_m;
        done_nxt     = 1'b0;
        result_nxt   = result;
        len_clip     = (e_len > MAX_LEN) ? MAX_LEN : e_len;

        case (state)
            IDLE: begin
                // busy is still high during the done cycle, so a start
                // arriving then is not taken.
                if (start && !busy) begin
                    e_nxt        = in_e;
                    len_zero_nxt = (len_clip == '0);
                    idx_nxt      = IW'(len_clip - EW'(1));
                    acc_nxt      = in_r;
                    mm_m_nxt     = in_m;
                    mm_a_nxt     = in_x;
                    mm_b_nxt     = in_r2;
                    mm_start_nxt = 1'b1;
                    state_nxt    = TO_MONT_W;
                end
            end
            TO_MONT_W: begin
                if (mm_done) begin
                    xt_nxt       = mm_result;
                    mm_a_nxt     = acc;
                    mm_start_nxt = 1'b1;
                    if (len_zero) begin
                        mm_b_nxt  = ONE;
                        state_nxt = FROM_W;
                    end else begin
                        mm_b_nxt  = acc;
                        state_nxt = SQ_W;
                    end
                end
            end
            SQ_W: begin
                if (mm_done) begin
                    acc_nxt      = mm_result;
                    mm_a_nxt     = mm_result;
                    mm_start_nxt = 1'b1;
                    if (e_reg[idx]) begin
                        mm_b_nxt  = xt;
                        state_nxt = MUL_W;
                    end else if (idx == '0) begin
                        mm_b_nxt  = ONE;
                        state_nxt = FROM_W;
                    end else begin
                        idx_nxt  = idx - 1'b1;
                        mm_b_nxt = mm_result;
                    end
                end
            end
            MUL_W: begin
                if (mm_done) begin
                    acc_nxt      = mm_result;
                    mm_a_nxt     = mm_result;
                    mm_start_nxt = 1'b1;
                    if (idx == '0) begin
                        mm_b_nxt  = ONE;
                        state_nxt = FROM_W;
                    end else begin
                        idx_nxt   = idx - 1'b1;
                        mm_b_nxt  = mm_result;
                        state_nxt = SQ_W;
                    end
                end
            end
            FROM_W: begin
                if (mm_done) begin
                    result_nxt = mm_result;
                    done_nxt   = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Stretches busy over the done cycle so it falls one cycle later.
        busy_nxt = (state_nxt != IDLE) || done_nxt;
    end

endmodule
